operand_collector: RTL
======================

# operand_collector

Parameterised operand-gathering stage between instruction decode and the ALU of the CPU datapath. It accepts an opcode command and works out from a shared decode function how many operands the opcode needs (0 to MAX_OPS). It then captures that many words from the data bus using a valid/ready handshake and presents them as one operand bundle with its own valid/ready handshake. It generalises the fixed two-temporary operand latch to any width and operand depth, and adds flush and back-pressure.

## Interface
- DATA_W, 8, operand width in bits
- MAX_OPS, 2, operand slots (1..4); opcode operand counts above this are clamped to MAX_OPS
- OPC_W, 5, opcode width
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  opcode command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- opcode  in  OPC_W  opcode qualified by cmd_valid
- din_valid  in  1  operand word offered
- din_ready  out  1  operand accepted when din_valid & din_ready
- din  in  DATA_W  operand word
- flush  in  1  synchronous abort of the current command
- ops_out  out  MAX_OPS*DATA_W  operand bundle; slot k occupies bits [k*DATA_W +: DATA_W]
- nops_out  out  3  number of valid slots in the bundle
- ops_valid  out  1  bundle valid
- ops_ready  in  1  consumer accepts the bundle when ops_valid & ops_ready
- busy  out  1  high whenever state != IDLE

## Operation
- op_count(opcode) decode:
  - 5'b00100..5'b01100 → 2
  - 5'b01101..5'b10011, excluding 5'b01110 → 1
  - 5'b10100..5'b10111 → 3
  - everything else → 0
  - Effective count N = min(op_count, MAX_OPS).
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - cmd_ready = 1.
  - On a command handshake with N > 0: latch N, clear every slot to 0, set index to 0, go to COLLECT.
  - On a command handshake with N = 0: the command is consumed and dropped, with no bundle; stay in IDLE.
- COLLECT:
  - din_ready = 1.
  - On each din handshake: slot[index] <= din, then index increments.
  - When the handshake is on index N-1, go to HOLD.
  - Slots at index >= N stay 0.
- HOLD:
  - ops_valid = 1, and ops_out and nops_out are held stable until the consumer handshakes.
  - On ops_ready the state goes to IDLE.
  - cmd_ready = ops_ready in HOLD. A command offered in the same cycle as the bundle handshake is accepted and processed exactly as in IDLE, so the next state is COLLECT, or IDLE if N = 0.
- din_ready = 0 outside COLLECT. cmd_ready = 0 in COLLECT.
- flush:
  - When high, the next state is IDLE, and slots, index, nops_out and ops_valid are cleared.
  - A handshake on cmd, din or ops in the flush cycle is ignored.
  - flush has priority over every other event.
- Reset: state IDLE. ops_out = 0, nops_out = 0, ops_valid = 0, busy = 0, din_ready = 0, cmd_ready = 1 once rstn is released. Reset takes effect mid-collection or mid-hold with no residue.

## Timing
- A command accepted at edge T asserts din_ready from T+1.
- The last operand accepted at edge E asserts ops_valid from E+1.
- Minimum latency, command to bundle valid: N+1 cycles.
- Back-to-back command: the bundle handshake and the new command share one edge, so din_ready is high on the next cycle.
- All outputs are registered or decoded from the state register only. There is no combinational path from din, din_valid or cmd_valid to any output. cmd_ready in HOLD follows ops_ready combinationally, which is the only exception.

## Structure
- Shared package cpu_pkg holds:
  - the opcode range constants and the 5'b01110 exclusion
  - the op_count function
  - the state enum {IDLE, COLLECT, HOLD}
- Sub-module operand_slot_bank:
  - MAX_OPS × DATA_W register array
  - inputs: write index, write enable, clear
  - output: the flat ops_out bus
- The FSM and counters live in the top module.

## Test plan
- Reset mid-operation: MAX_OPS=2, opcode 5'b00100, din 8'h12 accepted, rstn pulsed low → state IDLE, ops_out=0, nops_out=0, ops_valid=0 immediately.
- Two-operand command: opcode 5'b00101, then din 8'hA5 and 8'h3C → ops_valid one cycle after 8'h3C, ops_out=16'h3CA5, nops_out=2. Hold ops_ready low 5 cycles → bundle stable and din_ready=0.
- One-operand and zero-operand commands:
  - opcode 5'b10000 with din 8'h7F → ops_out=16'h007F, nops_out=1.
  - opcode 5'b01110, and separately 5'b00000 → cmd accepted, no ops_valid, busy stays 0.
- Three-operand clamp:
  - MAX_OPS=4, opcode 5'b10100, din 1, 2, 3 → nops_out=3, ops_out=32'h00030201.
  - MAX_OPS=2, same stimulus → nops_out=2, and the third word is not accepted because din_ready=0.
- Flush and back-to-back:
  - flush asserted after 1 of 2 operands → IDLE next cycle, no bundle; the next command starts from slot 0.
  - In HOLD, ops_ready and cmd_valid (opcode 5'b00110) high together → din_ready=1 on the next cycle, with no idle bubble.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the CPU datapath: opcode operand-count
// ranges, the decode function and the operand collector state encoding.
package cpu_pkg;

    localparam logic [4:0] OPC2_LO   = 5'b00100;
    localparam logic [4:0] OPC2_HI   = 5'b01100;
    localparam logic [4:0] OPC1_LO   = 5'b01101;
    localparam logic [4:0] OPC1_HI   = 5'b10011;
    localparam logic [4:0] OPC1_EXCL = 5'b01110;
    localparam logic [4:0] OPC3_LO   = 5'b10100;
    localparam logic [4:0] OPC3_HI   = 5'b10111;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} oc_state_e;

    function automatic logic [2:0] op_count(input logic [4:0] opc);
        logic [2:0] cnt;
        cnt = 3'd0;
        if (opc >= OPC2_LO && opc <= OPC2_HI)
            cnt = 3'd2;
        else if (opc >= OPC1_LO && opc <= OPC1_HI && opc != OPC1_EXCL)
            cnt = 3'd1;
        else if (opc >= OPC3_LO && opc <= OPC3_HI)
            cnt = 3'd3;
        return cnt;
    endfunction

endpackage

// File: rtl/operand_slot_bank.sv
// MAX_OPS x DATA_W operand registers; clear wins over write so a new
// command or flush always starts from an all-zero bundle.
module operand_slot_bank #(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 2,
    parameter int IDX_W   = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr_i,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          widx_i,
    input  logic [DATA_W-1:0]         din_i,
    output logic [MAX_OPS*DATA_W-1:0] ops_o
);

    logic [MAX_OPS-1:0][DATA_W-1:0] slot_q;

    for (genvar k = 0; k < MAX_OPS; k++) begin : g_slot
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                slot_q[k] <= '0;
            else if (clr_i)
                slot_q[k] <= '0;
            else if (we_i && widx_i == IDX_W'(k))
                slot_q[k] <= din_i;
        end
    end

    assign ops_o = slot_q;

endmodule

// File: rtl/operand_collector.sv
// Operand-gathering stage: decodes the operand count of a command, collects
// that many words from the data bus and presents them as one bundle.
module operand_collector
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 2,
    parameter int OPC_W   = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OPC_W-1:0]          opcode,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [DATA_W-1:0]         din,
    input  logic                      flush,
    output logic [MAX_OPS*DATA_W-1:0] ops_out,
    output logic [2:0]                nops_out,
    output logic                      ops_valid,
    input  logic                      ops_ready,
    output logic                      busy
);

    localparam int IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;

    oc_state_e        state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [2:0] cnt_raw, n_eff;
    logic       start, din_fire, last;

    assign cnt_raw  = op_count(5'(opcode));
    assign n_eff    = (cnt_raw > 3'(MAX_OPS)) ? 3'(MAX_OPS) : cnt_raw;
    // Zero-operand commands are consumed by the handshake but never start.
    assign start    = cmd_valid & cmd_ready & ~flush & (n_eff != 3'd0);
    assign din_fire = din_valid & din_ready & ~flush;
    assign last     = din_fire & (idx_q == IDX_W'(n_q - 3'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (last)  state_d = HOLD;
            HOLD:    if (ops_ready) state_d = start ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        ops_valid = 1'b0;
        busy      = 1'b1;
        nops_out  = 3'd0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            COLLECT: din_ready = 1'b1;
            HOLD: begin
                ops_valid = 1'b1;
                cmd_ready = ops_ready;
                nops_out  = n_q;
            end
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        n_d   = n_q;
        idx_d = idx_q;
        if (flush) begin
            n_d   = 3'd0;
            idx_d = '0;
        end else if (start) begin
            n_d   = n_eff;
            idx_d = '0;
        end else if (din_fire) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q   <= 3'd0;
            idx_q <= '0;
        end else begin
            n_q   <= n_d;
            idx_q <= idx_d;
        end
    end

    operand_slot_bank #(
        .DATA_W  (DATA_W),
        .MAX_OPS (MAX_OPS),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (flush | start),
        .we_i   (din_fire),
        .widx_i (idx_q),
        .din_i  (din),
        .ops_o  (ops_out)
    );

endmodule
